// File: rtl/alu_wb_scheduler.sv
// Issue/writeback scheduler for the add/bool/shift result mux: reserves writeback slots,
// drives the one-hot mux select and a registered result tag. Optional ALU_WB_SCHED_PERF_EN adds perf counters.
module alu_wb_scheduler #(
    parameter int TAG_W     = 4,
    parameter int ADD_LAT   = 1,
    parameter int BOOL_LAT  = 1,
    parameter int SHIFT_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_class,
    input  logic [TAG_W-1:0] op_tag,
    output logic             issue_add,
    output logic             issue_bool,
    output logic             issue_shift,
    output logic [2:0]       mux_en,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err,
    input  logic             flush_req,
    output logic             flush_done
`ifdef ALU_WB_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_issued,
    output logic [31:0]      perf_stalls
`endif
);

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int MAXL = max3(ADD_LAT, BOOL_LAT, SHIFT_LAT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt;

    // Slot k holds the op whose mux cycle is k-1 cycles from now; slot 1 drives mux_en.
    logic             slot_vld_r [1:MAXL];
    logic [TAG_W-1:0] slot_tag_r [1:MAXL];
    logic [2:0]       slot_oh_r  [1:MAXL];
    logic             slot_err_r [1:MAXL];

    logic             sh_vld_s [1:MAXL];
    logic [TAG_W-1:0] sh_tag_s [1:MAXL];
    logic [2:0]       sh_oh_s  [1:MAXL];
    logic             sh_err_s [1:MAXL];

    int               lat_sel_s;
    logic [2:0]       cls_oh_s;
    logic             slot_hit_s;
    logic             accept_s;
    logic             busy_any_s;

    logic             res_valid_r;
    logic [TAG_W-1:0] res_tag_r;
    logic             res_err_r;
    logic             flush_done_r;

    // Reservation view after this cycle's shift, class decode and acceptance.
    always_comb begin
        for (int k = 1; k <= MAXL; k++) begin
            sh_vld_s[k] = 1'b0;
            sh_tag_s[k] = {TAG_W{1'b0}};
            sh_oh_s[k]  = 3'b000;
            sh_err_s[k] = 1'b0;
        end
        for (int k = 1; k < MAXL; k++) begin
            sh_vld_s[k] = slot_vld_r[k+1];
            sh_tag_s[k] = slot_tag_r[k+1];
            sh_oh_s[k]  = slot_oh_r[k+1];
            sh_err_s[k] = slot_err_r[k+1];
        end

        case (op_class)
            2'd0:    begin lat_sel_s = ADD_LAT;   cls_oh_s = 3'b001; end
            2'd1:    begin lat_sel_s = BOOL_LAT;  cls_oh_s = 3'b010; end
            2'd2:    begin lat_sel_s = SHIFT_LAT; cls_oh_s = 3'b100; end
            default: begin lat_sel_s = 1;         cls_oh_s = 3'b000; end
        endcase

        slot_hit_s = 1'b0;
        for (int k = 1; k <= MAXL; k++) begin
            slot_hit_s = slot_hit_s | ((k == lat_sel_s) ? sh_vld_s[k] : 1'b0);
        end

        op_ready    = rst_n & (state_r == ST_RUN) & ~flush_req & ~slot_hit_s;
        accept_s    = op_valid & op_ready;
        issue_add   = accept_s & cls_oh_s[0];
        issue_bool  = accept_s & cls_oh_s[1];
        issue_shift = accept_s & cls_oh_s[2];
    end

    // Any reservation still outstanding.
    always_comb begin
        busy_any_s = 1'b0;
        for (int k = 1; k <= MAXL; k++) begin
            busy_any_s = busy_any_s | slot_vld_r[k];
        end
    end

    // Reservation slots: shift down each cycle, insert accepted op at its latency slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= MAXL; k++) begin
                slot_vld_r[k] <= 1'b0;
                slot_tag_r[k] <= {TAG_W{1'b0}};
                slot_oh_r[k]  <= 3'b000;
                slot_err_r[k] <= 1'b0;
            end
        end else begin
            for (int k = 1; k <= MAXL; k++) begin
                if (accept_s && (k == lat_sel_s)) begin
                    slot_vld_r[k] <= 1'b1;
                    slot_tag_r[k] <= op_tag;
                    slot_oh_r[k]  <= cls_oh_s;
                    slot_err_r[k] <= (op_class == 2'd3);
                end else begin
                    slot_vld_r[k] <= sh_vld_s[k];
                    slot_tag_r[k] <= sh_tag_s[k];
                    slot_oh_r[k]  <= sh_oh_s[k];
                    slot_err_r[k] <= sh_err_s[k];
                end
            end
        end
    end

    // Result tag pipe aligned with the registered mux output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_tag_r   <= {TAG_W{1'b0}};
            res_err_r   <= 1'b0;
        end else begin
            res_valid_r <= slot_vld_r[1];
            res_tag_r   <= slot_tag_r[1];
            res_err_r   <= slot_vld_r[1] & slot_err_r[1];
        end
    end

    // Flush FSM next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush_req) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!busy_any_s) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: state_nxt = ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    // Flush FSM state and done pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_RUN;
            flush_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            flush_done_r <= (state_nxt == ST_DONE);
        end
    end

    assign mux_en     = slot_oh_r[1];
    assign res_valid  = res_valid_r;
    assign res_tag    = res_tag_r;
    assign res_err    = res_err_r;
    assign flush_done = flush_done_r;

`ifdef ALU_WB_SCHED_PERF_EN
    logic [31:0] perf_issued_r;
    logic [31:0] perf_stalls_r;

    // Saturating accept and stall counters; survive flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_r <= 32'd0;
            perf_stalls_r <= 32'd0;
        end else begin
            if (accept_s && (perf_issued_r != 32'hFFFF_FFFF)) begin
                perf_issued_r <= perf_issued_r + 32'd1;
            end else begin
                perf_issued_r <= perf_issued_r;
            end
            if ((state_r == ST_RUN) && op_valid && !op_ready && (perf_stalls_r != 32'hFFFF_FFFF)) begin
                perf_stalls_r <= perf_stalls_r + 32'd1;
            end else begin
                perf_stalls_r <= perf_stalls_r;
            end
        end
    end

    assign perf_issued = perf_issued_r;
    assign perf_stalls = perf_stalls_r;
`endif

endmodule
